// File: rtl/info_dram_arbiter_if.sv
// AXI4-Lite single-beat bus between the record arbiter and the DRAM bridge.
// The master modport is the arbiter side and the slave modport is the bridge side.
interface info_dram_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 64
);
    logic              ar_valid;
    logic [ADDR_W-1:0] ar_addr;
    logic              ar_ready;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_ready;
    logic              aw_valid;
    logic [ADDR_W-1:0] aw_addr;
    logic              aw_ready;
    logic              w_valid;
    logic [DATA_W-1:0] w_data;
    logic              w_ready;
    logic              b_valid;
    logic [1:0]        b_resp;
    logic              b_ready;

    modport master (
        output ar_valid, ar_addr, input  ar_ready,
        input  r_valid, r_data, r_resp, output r_ready,
        output aw_valid, aw_addr, input  aw_ready,
        output w_valid, w_data, input  w_ready,
        input  b_valid, b_resp, output b_ready
    );

    modport slave (
        input  ar_valid, ar_addr, output ar_ready,
        output r_valid, r_data, r_resp, input  r_ready,
        input  aw_valid, aw_addr, output aw_ready,
        input  w_valid, w_data, output w_ready,
        output b_valid, b_resp, input  b_ready
    );
endinterface

// File: rtl/info_dram_arbiter.sv
// Round-robin arbiter sharing one DRAM AXI4-Lite port between the buyer (0) and
// seller (1) record requesters; one single-beat transaction in flight at a time.
module info_dram_arbiter #(
    parameter int                ADDR_W    = 17,
    parameter int                DATA_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 17'h10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [7:0]        req_id0,
    input  logic [7:0]        req_id1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    info_dram_arbiter_if.master axi
);
    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] RD_ADDR      = 3'd1;
    localparam logic [2:0] RD_DATA      = 3'd2;
    localparam logic [2:0] WR_ADDR_DATA = 3'd3;
    localparam logic [2:0] WR_RESP      = 3'd4;
    localparam logic [2:0] DONE         = 3'd5;

    logic [2:0]        state;
    logic              last_grant;
    logic              grant;
    logic              sel;
    logic [7:0]        sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_write;
    logic [DATA_W-1:0] sel_wdata;
    logic              aw_ok;
    logic              w_ok;

    always_comb begin
        sel = 1'b0;
        if (&req_valid) sel = ~last_grant;
        else            sel = ~req_valid[0];
        sel_id    = sel ? req_id1 : req_id0;
        sel_write = sel ? req_write[1] : req_write[0];
        sel_wdata = sel ? req_wdata1 : req_wdata0;
        sel_addr  = BASE_ADDR + ADDR_W'({sel_id, 3'b000});
        // A channel counts as finished if it already dropped or handshakes now.
        aw_ok = !axi.aw_valid || axi.aw_ready;
        w_ok  = !axi.w_valid  || axi.w_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant        <= 1'b0;
            done         <= '0;
            err          <= 1'b0;
            rdata        <= '0;
            axi.ar_valid <= 1'b0;
            axi.ar_addr  <= '0;
            axi.r_ready  <= 1'b0;
            axi.aw_valid <= 1'b0;
            axi.aw_addr  <= '0;
            axi.w_valid  <= 1'b0;
            axi.w_data   <= '0;
            axi.b_ready  <= 1'b0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant      <= sel;
                        last_grant <= sel;
                        if (sel_write) begin
                            axi.aw_valid <= 1'b1;
                            axi.aw_addr  <= sel_addr;
                            axi.w_valid  <= 1'b1;
                            axi.w_data   <= sel_wdata;
                            state        <= WR_ADDR_DATA;
                        end else begin
                            axi.ar_valid <= 1'b1;
                            axi.ar_addr  <= sel_addr;
                            state        <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (axi.ar_ready) begin
                        axi.ar_valid <= 1'b0;
                        axi.r_ready  <= 1'b1;
                        state        <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi.r_valid) begin
                        rdata       <= axi.r_data;
                        err         <= (axi.r_resp != 2'b00);
                        done        <= {grant, ~grant};
                        axi.r_ready <= 1'b0;
                        state       <= DONE;
                    end
                end
                WR_ADDR_DATA: begin
                    if (axi.aw_valid && axi.aw_ready) axi.aw_valid <= 1'b0;
                    if (axi.w_valid && axi.w_ready)   axi.w_valid  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        axi.b_ready <= 1'b1;
                        state       <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.b_valid) begin
                        err         <= (axi.b_resp != 2'b00);
                        done        <= {grant, ~grant};
                        axi.b_ready <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    a_done_onehot: assert property (@(posedge clk) disable iff (rst) done != 2'b11);
    a_no_ar_aw:    assert property (@(posedge clk) disable iff (rst) !(axi.ar_valid && axi.aw_valid));
    a_ar_hold:     assert property (@(posedge clk) disable iff (rst)
                                    (axi.ar_valid && !axi.ar_ready) |=> axi.ar_valid);
    a_aw_hold:     assert property (@(posedge clk) disable iff (rst)
                                    (axi.aw_valid && !axi.aw_ready) |=> axi.aw_valid);
    a_w_hold:      assert property (@(posedge clk) disable iff (rst)
                                    (axi.w_valid && !axi.w_ready) |=> axi.w_valid);
endmodule

// File: tb/tb_info_dram_arbiter.sv
// Bench for info_dram_arbiter: requester and AXI slave models advanced once per
// cycle on the falling edge, with a scoreboard of transactions in expected grant order.
module tb_info_dram_arbiter;
    typedef struct {
        bit          p;
        bit          wr;
        logic [7:0]  id;
        logic [63:0] wd;
        logic [63:0] rd;
        logic [1:0]  resp;
        bit          lat;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [7:0]  req_id0 = '0, req_id1 = '0;
    logic [63:0] req_wdata0 = '0, req_wdata1 = '0;
    logic [1:0]  done;
    logic [63:0] rdata;
    logic        err;

    info_dram_arbiter_if #(.ADDR_W(17), .DATA_W(64)) axi ();

    info_dram_arbiter #(.ADDR_W(17), .DATA_W(64), .BASE_ADDR(17'h10000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_id0(req_id0), .req_id1(req_id1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .done(done), .rdata(rdata), .err(err),
        .axi(axi)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   raise_cyc [2];
    txn_t exp_q [$];
    txn_t port_q0 [$];
    txn_t port_q1 [$];

    int ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0, b_lat = 0;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    int aw_hi, w_hi;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_got, w_got, r_pend, b_pend;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] addr_of(input logic [7:0] id);
        return 17'h10000 + 17'(id) * 17'd8;
    endfunction

    task automatic model_clear();
        exp_q.delete(); port_q0.delete(); port_q1.delete();
        req_valid = '0;
        axi.ar_ready = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
        axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = '0;
        axi.b_valid = 1'b0; axi.b_resp = '0;
        {ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_got, w_got, r_pend, b_pend} = '0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        aw_hi = 0; w_hi = 0;
    endtask

    task automatic issue(input bit p, input bit wr, input logic [7:0] id, input logic [63:0] wd,
                         input logic [63:0] rd, input logic [1:0] resp, input bit lat);
        txn_t t;
        t.p = p; t.wr = wr; t.id = id; t.wd = wd; t.rd = rd; t.resp = resp; t.lat = lat;
        exp_q.push_back(t);
        if (p) port_q1.push_back(t);
        else   port_q0.push_back(t);
    endtask

    task automatic tick();
        txn_t e;
        @(negedge clk);
        cyc++;
        chk("ar_aw_overlap", 64'(axi.ar_valid & axi.aw_valid), 64'd0);
        if (axi.b_ready) chk("b_ready_early", 64'(axi.aw_valid | axi.w_valid), 64'd0);
        if (done != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 64'(done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done", 64'(done), 64'(e.p ? 2'b10 : 2'b01));
                chk("err", 64'(err), 64'(e.resp != 2'b00));
                if (!e.wr) chk("rdata", rdata, e.rd);
                if (e.lat) chk("latency", 64'(cyc - raise_cyc[e.p]), 64'd3);
            end
            req_valid = req_valid & ~done;
        end
        // consequences of the handshakes that completed on the last rising edge
        if (ar_hs) begin ar_hs = 0; r_pend = 1; r_cnt = 0; end
        if (r_hs)  begin r_hs = 0; axi.r_valid = 1'b0; end
        if (aw_hs) begin aw_hs = 0; aw_got = 1; end
        if (w_hs)  begin w_hs = 0; w_got = 1; end
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; end
        if (b_hs)  begin b_hs = 0; axi.b_valid = 1'b0; end
        aw_hi += int'(axi.aw_valid);
        w_hi  += int'(axi.w_valid);
        axi.ar_ready = axi.ar_valid && ar_cnt >= ar_lat; ar_cnt = axi.ar_valid ? ar_cnt + 1 : 0;
        axi.aw_ready = axi.aw_valid && aw_cnt >= aw_lat; aw_cnt = axi.aw_valid ? aw_cnt + 1 : 0;
        axi.w_ready  = axi.w_valid  && w_cnt  >= w_lat;  w_cnt  = axi.w_valid  ? w_cnt + 1 : 0;
        if (r_pend && exp_q.size() != 0) begin
            if (r_cnt >= r_lat) begin
                axi.r_valid = 1'b1; axi.r_data = exp_q[0].rd; axi.r_resp = exp_q[0].resp; r_pend = 0;
            end else r_cnt++;
        end
        if (b_pend && exp_q.size() != 0) begin
            if (b_cnt >= b_lat) begin
                axi.b_valid = 1'b1; axi.b_resp = exp_q[0].resp; b_pend = 0;
            end else b_cnt++;
        end
        ar_hs = axi.ar_valid && axi.ar_ready;
        aw_hs = axi.aw_valid && axi.aw_ready;
        w_hs  = axi.w_valid && axi.w_ready;
        r_hs  = axi.r_valid && axi.r_ready;
        b_hs  = axi.b_valid && axi.b_ready;
        if (exp_q.size() != 0) begin
            if (ar_hs) chk("ar_addr", 64'(axi.ar_addr), 64'(addr_of(exp_q[0].id)));
            if (aw_hs) chk("aw_addr", 64'(axi.aw_addr), 64'(addr_of(exp_q[0].id)));
            if (w_hs)  chk("w_data", axi.w_data, exp_q[0].wd);
        end
        if (!req_valid[0] && port_q0.size() != 0) begin
            e = port_q0.pop_front();
            req_id0 = e.id; req_wdata0 = e.wd; req_write[0] = e.wr; req_valid[0] = 1'b1;
            raise_cyc[0] = cyc;
        end
        if (!req_valid[1] && port_q1.size() != 0) begin
            e = port_q1.pop_front();
            req_id1 = e.id; req_wdata1 = e.wd; req_write[1] = e.wr; req_valid[1] = 1'b1;
            raise_cyc[1] = cyc;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) chk({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        model_clear();
        do_reset();
        chk("rst_ar_valid", 64'(axi.ar_valid), 64'd0);
        chk("rst_aw_w_valid", 64'({axi.aw_valid, axi.w_valid}), 64'd0);
        chk("rst_readies", 64'({axi.r_ready, axi.b_ready}), 64'd0);
        chk("rst_done_err", 64'({done, err}), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_addrs", 64'({axi.ar_addr, axi.aw_addr}), 64'd0);
        chk("rst_w_data", axi.w_data, 64'd0);

        issue(1'b0, 1'b0, 8'h05, '0, 64'hDEAD_BEEF_0123_4567, 2'b00, 1'b1);
        drain("single_read");
        chk("rdata_held", rdata, 64'hDEAD_BEEF_0123_4567);

        issue(1'b1, 1'b1, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, '0, 2'b00, 1'b1);
        drain("single_write");

        aw_lat = 1; w_lat = 4; aw_hi = 0; w_hi = 0;
        issue(1'b0, 1'b1, 8'h10, 64'h0123_4567_89AB_CDEF, '0, 2'b00, 1'b0);
        drain("split_write");
        chk("aw_valid_cycles", 64'(aw_hi), 64'd2);
        chk("w_valid_cycles", 64'(w_hi), 64'd5);
        aw_lat = 0; w_lat = 0; r_lat = 2; b_lat = 3;

        issue(1'b0, 1'b0, 8'h03, '0, 64'h1111_2222_3333_4444, 2'b10, 1'b0);
        drain("err_read");
        issue(1'b1, 1'b0, 8'h40, '0, 64'h5555_6666_7777_8888, 2'b00, 1'b0);
        drain("good_read");
        issue(1'b0, 1'b1, 8'h80, 64'hFEED_FACE_CAFE_F00D, '0, 2'b01, 1'b0);
        drain("err_write");
        chk("rdata_kept_by_write", rdata, 64'h5555_6666_7777_8888);
        r_lat = 0; b_lat = 0;

        do_reset();
        issue(1'b0, 1'b0, 8'h01, '0, 64'hA000_0000_0000_0001, 2'b00, 1'b0);
        issue(1'b1, 1'b0, 8'h02, '0, 64'hB000_0000_0000_0002, 2'b00, 1'b0);
        issue(1'b0, 1'b0, 8'h03, '0, 64'hA000_0000_0000_0003, 2'b00, 1'b0);
        issue(1'b1, 1'b0, 8'h04, '0, 64'hB000_0000_0000_0004, 2'b00, 1'b0);
        drain("contention");

        r_lat = 50;
        issue(1'b0, 1'b0, 8'h22, '0, 64'h0BAD_0BAD_0BAD_0BAD, 2'b00, 1'b0);
        for (int i = 0; i < 20 && !axi.r_ready; i++) tick();
        chk("reached_rd_data", 64'(axi.r_ready), 64'd1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_ar_valid", 64'(axi.ar_valid), 64'd0);
        chk("midrst_r_ready", 64'(axi.r_ready), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        model_clear();
        r_lat = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        issue(1'b0, 1'b0, 8'h31, '0, 64'hC000_0000_0000_0031, 2'b00, 1'b0);
        issue(1'b1, 1'b0, 8'h32, '0, 64'hD000_0000_0000_0032, 2'b00, 1'b0);
        drain("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
